// File: rtl/cr_bmu_ibus_pkg.sv
// Shared definitions for the BMU instruction-bus fetch controller.
package cr_bmu_ibus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DENY = 2'd3
  } ibus_state_e;

  localparam logic [31:0] DENY_BASE_DEF = 32'hE000_0000;
  localparam logic [31:0] DENY_MASK_DEF = 32'hF000_0000;

endpackage

// File: rtl/cr_bmu_ibus_acc_chk.sv
// Instruction-fetch access check: misaligned addresses and the configured
// denied region are refused.
module cr_bmu_ibus_acc_chk
  import cr_bmu_ibus_pkg::*;
#(
  parameter bit          DENY_EN   = 1'b1,
  parameter logic [31:0] DENY_BASE = DENY_BASE_DEF,
  parameter logic [31:0] DENY_MASK = DENY_MASK_DEF
) (
  input  logic [31:0] addr,
  output logic        deny
);

  logic misalign;
  logic region_hit;

  // Deny on a non-word-aligned fetch or a hit in the masked region.
  always_comb begin
    misalign   = (addr[1:0] != 2'b00);
    region_hit = DENY_EN && ((addr & DENY_MASK) == DENY_BASE);
    deny       = misalign || region_hit;
  end

endmodule

// File: rtl/cr_bmu_ibus_fetch_ctrl.sv
// Single-outstanding instruction fetch controller between the IFU and the
// TCIP ibus slave. Denied fetches are answered locally because the slave
// grants them but never completes them.
//
// Handshakes: the IFU request is accepted in the cycle bmu_ifu_grnt is high;
// the bus request is held from REQ entry until the slave grants or a flush
// drops it, with address and deny flag stable; bmu_ifu_trans_cmplt is a
// one-cycle pulse carrying acc_err, data_vld and data for that cycle only.
module cr_bmu_ibus_fetch_ctrl
  import cr_bmu_ibus_pkg::*;
#(
  parameter bit          DENY_EN   = 1'b1,
  parameter logic [31:0] DENY_BASE = DENY_BASE_DEF,
  parameter logic [31:0] DENY_MASK = DENY_MASK_DEF
) (
  input  logic        sel_cpuclk,
  input  logic        cpurst_b,
  input  logic        ifu_bmu_req,
  input  logic [31:0] ifu_bmu_addr,
  input  logic        ifu_bmu_flush,
  output logic        bmu_ifu_grnt,
  output logic        bmu_ifu_trans_cmplt,
  output logic        bmu_ifu_data_vld,
  output logic [31:0] bmu_ifu_data,
  output logic        bmu_ifu_acc_err,
  output logic        bmu_tcipif_ibus_req,
  output logic [31:0] bmu_tcipif_ibus_addr,
  output logic        bmu_tcipif_ibus_write,
  output logic        bmu_tcipif_ibus_acc_deny,
  input  logic        tcipif_bmu_ibus_grnt,
  input  logic        tcipif_bmu_ibus_trans_cmplt,
  input  logic        tcipif_bmu_ibus_acc_err,
  input  logic        tcipif_bmu_ibus_data_vld,
  input  logic [31:0] tcipif_bmu_ibus_data,
  output logic [1:0]  dbg_fetch_state
);

  ibus_state_e state_q, state_nxt;
  logic        drop_q, drop_nxt;
  logic [31:0] addr_q;
  logic        deny_q;
  logic        deny_w;
  logic        addr_ld;
  logic        rsp_ld;
  logic        rsp_err;
  logic        rsp_vld;
  logic [31:0] rsp_data;

  cr_bmu_ibus_acc_chk #(
    .DENY_EN   (DENY_EN),
    .DENY_BASE (DENY_BASE),
    .DENY_MASK (DENY_MASK)
  ) u_acc_chk (
    .addr (ifu_bmu_addr),
    .deny (deny_w)
  );

  // State and drop-flag registers.
  always_ff @(posedge sel_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      drop_q  <= drop_nxt;
    end
  end

  // Next-state, handshake outputs and response selection.
  always_comb begin
    state_nxt           = state_q;
    drop_nxt            = drop_q;
    bmu_ifu_grnt        = 1'b0;
    bmu_tcipif_ibus_req = 1'b0;
    addr_ld             = 1'b0;
    rsp_ld              = 1'b0;
    rsp_err             = 1'b0;
    rsp_vld             = 1'b0;
    rsp_data            = 32'h0;
    case (state_q)
      IDLE: begin
        drop_nxt     = 1'b0;
        bmu_ifu_grnt = ifu_bmu_req && !ifu_bmu_flush;
        if (bmu_ifu_grnt) begin
          addr_ld   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        bmu_tcipif_ibus_req = 1'b1;
        if (tcipif_bmu_ibus_grnt) begin
          // A flush racing the grant cannot retract it; remember to drop.
          drop_nxt = drop_q || ifu_bmu_flush;
          if (deny_q) begin
            state_nxt = DENY;
            // Local error response becomes visible while in DENY.
            if (!drop_q && !ifu_bmu_flush) begin
              rsp_ld  = 1'b1;
              rsp_err = 1'b1;
            end
          end else begin
            state_nxt = WAIT;
          end
        end else if (ifu_bmu_flush) begin
          drop_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        drop_nxt = drop_q || ifu_bmu_flush;
        if (tcipif_bmu_ibus_trans_cmplt) begin
          state_nxt = IDLE;
          drop_nxt  = 1'b0;
          if (!drop_q && !ifu_bmu_flush) begin
            rsp_ld   = 1'b1;
            rsp_err  = tcipif_bmu_ibus_acc_err;
            rsp_vld  = tcipif_bmu_ibus_data_vld;
            rsp_data = tcipif_bmu_ibus_data_vld ? tcipif_bmu_ibus_data : 32'h0;
          end
        end
      end
      DENY: begin
        drop_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        drop_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Address and deny flag captured on IFU acceptance.
  always_ff @(posedge sel_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      addr_q <= 32'h0;
      deny_q <= 1'b0;
    end else if (addr_ld) begin
      addr_q <= ifu_bmu_addr;
      deny_q <= deny_w;
    end
  end

  // Response registers: loaded for one cycle, otherwise cleared.
  always_ff @(posedge sel_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      bmu_ifu_trans_cmplt <= 1'b0;
      bmu_ifu_acc_err     <= 1'b0;
      bmu_ifu_data_vld    <= 1'b0;
      bmu_ifu_data        <= 32'h0;
    end else begin
      bmu_ifu_trans_cmplt <= rsp_ld;
      bmu_ifu_acc_err     <= rsp_err;
      bmu_ifu_data_vld    <= rsp_vld;
      bmu_ifu_data        <= rsp_data;
    end
  end

  assign bmu_tcipif_ibus_addr     = addr_q;
  assign bmu_tcipif_ibus_acc_deny = deny_q;
  assign bmu_tcipif_ibus_write    = 1'b0;
  assign dbg_fetch_state          = state_q;

endmodule

// File: tb/tb_cr_bmu_ibus_fetch_ctrl.sv
// Directed bench for cr_bmu_ibus_fetch_ctrl with a TCIP-like slave model.
module tb_cr_bmu_ibus_fetch_ctrl;

  logic        sel_cpuclk = 1'b0;
  logic        cpurst_b   = 1'b0;
  logic        ifu_bmu_req = 1'b0;
  logic [31:0] ifu_bmu_addr = 32'h0;
  logic        ifu_bmu_flush = 1'b0;
  logic        bmu_ifu_grnt;
  logic        bmu_ifu_trans_cmplt;
  logic        bmu_ifu_data_vld;
  logic [31:0] bmu_ifu_data;
  logic        bmu_ifu_acc_err;
  logic        bmu_tcipif_ibus_req;
  logic [31:0] bmu_tcipif_ibus_addr;
  logic        bmu_tcipif_ibus_write;
  logic        bmu_tcipif_ibus_acc_deny;
  logic        tcip_grnt;
  logic        tcip_cmplt;
  logic        tcip_err;
  logic        tcip_vld;
  logic [31:0] tcip_data;
  logic [1:0]  dbg_fetch_state;

  // Slave model controls
  logic        gnt_en    = 1'b1;
  logic        auto_en   = 1'b1;
  logic        inj_cmplt = 1'b0;
  logic        cmplt_q   = 1'b0;
  logic        cfg_err   = 1'b0;
  logic        cfg_vld   = 1'b0;
  logic [31:0] cfg_data  = 32'h0;

  int total = 0;
  int bad   = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_e;

  cr_bmu_ibus_fetch_ctrl dut (
    .sel_cpuclk                  (sel_cpuclk),
    .cpurst_b                    (cpurst_b),
    .ifu_bmu_req                 (ifu_bmu_req),
    .ifu_bmu_addr                (ifu_bmu_addr),
    .ifu_bmu_flush               (ifu_bmu_flush),
    .bmu_ifu_grnt                (bmu_ifu_grnt),
    .bmu_ifu_trans_cmplt         (bmu_ifu_trans_cmplt),
    .bmu_ifu_data_vld            (bmu_ifu_data_vld),
    .bmu_ifu_data                (bmu_ifu_data),
    .bmu_ifu_acc_err             (bmu_ifu_acc_err),
    .bmu_tcipif_ibus_req         (bmu_tcipif_ibus_req),
    .bmu_tcipif_ibus_addr        (bmu_tcipif_ibus_addr),
    .bmu_tcipif_ibus_write       (bmu_tcipif_ibus_write),
    .bmu_tcipif_ibus_acc_deny    (bmu_tcipif_ibus_acc_deny),
    .tcipif_bmu_ibus_grnt        (tcip_grnt),
    .tcipif_bmu_ibus_trans_cmplt (tcip_cmplt),
    .tcipif_bmu_ibus_acc_err     (tcip_err),
    .tcipif_bmu_ibus_data_vld    (tcip_vld),
    .tcipif_bmu_ibus_data        (tcip_data),
    .dbg_fetch_state             (dbg_fetch_state)
  );

  // Clock
  always #5 sel_cpuclk = ~sel_cpuclk;

  // Slave: combinational grant, completion one cycle after a non-denied grant.
  assign tcip_grnt  = bmu_tcipif_ibus_req & gnt_en;
  always @(posedge sel_cpuclk)
    cmplt_q <= auto_en & tcip_grnt & ~bmu_tcipif_ibus_acc_deny;
  assign tcip_cmplt = cmplt_q | inj_cmplt;
  assign tcip_err   = tcip_cmplt & cfg_err;
  assign tcip_vld   = tcip_cmplt & cfg_vld;
  assign tcip_data  = cfg_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge sel_cpuclk);
    #1;
  endtask

  // Scoreboard: every IFU response must match the oldest expected one.
  always @(negedge sel_cpuclk) begin
    if (bmu_ifu_trans_cmplt) begin
      check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("rsp_payload", 64'({bmu_ifu_acc_err, bmu_ifu_data_vld, bmu_ifu_data}), 64'(mon_e));
      end
    end
  end

  // Denied fetch: local error response in N+2, slave never completes.
  task automatic deny_case(input logic [31:0] a);
    ifu_bmu_req = 1'b1; ifu_bmu_addr = a; #1;
    check("deny_grnt", 64'(bmu_ifu_grnt), 64'd1);
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    tick; ifu_bmu_req = 1'b0;
    check("deny_bus_req", 64'(bmu_tcipif_ibus_req), 64'd1);
    check("deny_flag", 64'(bmu_tcipif_ibus_acc_deny), 64'd1);
    tick;
    check("deny_cmplt", 64'(bmu_ifu_trans_cmplt), 64'd1);
    check("deny_err", 64'(bmu_ifu_acc_err), 64'd1);
    check("deny_data", 64'(bmu_ifu_data), 64'd0);
    check("deny_state", 64'(dbg_fetch_state), 64'd3);
    tick;
    check("deny_cmplt_clr", 64'(bmu_ifu_trans_cmplt), 64'd0);
    check("deny_idle", 64'(dbg_fetch_state), 64'd0);
    repeat (3) tick;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge sel_cpuclk);
    #1;
    check("rst_grnt", 64'(bmu_ifu_grnt), 64'd0);
    check("rst_cmplt", 64'(bmu_ifu_trans_cmplt), 64'd0);
    check("rst_bus_req", 64'(bmu_tcipif_ibus_req), 64'd0);
    check("rst_addr", 64'(bmu_tcipif_ibus_addr), 64'd0);
    check("rst_deny", 64'(bmu_tcipif_ibus_acc_deny), 64'd0);
    check("rst_data", 64'(bmu_ifu_data), 64'd0);
    check("rst_state", 64'(dbg_fetch_state), 64'd0);
    cpurst_b = 1'b1;
    tick;

    // Normal fetch, slave returns error without data
    cfg_err = 1'b1; cfg_vld = 1'b0; cfg_data = 32'h1234_5678;
    ifu_bmu_req = 1'b1; ifu_bmu_addr = 32'h0000_1000; #1;
    check("n_grnt", 64'(bmu_ifu_grnt), 64'd1);
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    tick; ifu_bmu_req = 1'b0;
    check("n_bus_req", 64'(bmu_tcipif_ibus_req), 64'd1);
    check("n_bus_addr", 64'(bmu_tcipif_ibus_addr), 64'h1000);
    check("n_deny", 64'(bmu_tcipif_ibus_acc_deny), 64'd0);
    check("n_write", 64'(bmu_tcipif_ibus_write), 64'd0);
    tick;
    check("n_wait_req", 64'(bmu_tcipif_ibus_req), 64'd0);
    check("n_wait_cmplt", 64'(bmu_ifu_trans_cmplt), 64'd0);
    tick;
    check("n_cmplt", 64'(bmu_ifu_trans_cmplt), 64'd1);
    check("n_err", 64'(bmu_ifu_acc_err), 64'd1);
    check("n_data_zero", 64'(bmu_ifu_data), 64'd0);
    tick;
    check("n_cmplt_clr", 64'(bmu_ifu_trans_cmplt), 64'd0);
    check("n_idle", 64'(dbg_fetch_state), 64'd0);

    // Denied region and misaligned fetches
    deny_case(32'hE000_0040);
    deny_case(32'h0000_1002);

    // Data fetch, then back-to-back grant in the response cycle
    cfg_err = 1'b0; cfg_vld = 1'b1; cfg_data = 32'hDEAD_BEEF;
    ifu_bmu_req = 1'b1; ifu_bmu_addr = 32'h0000_0100; #1;
    check("d_grnt", 64'(bmu_ifu_grnt), 64'd1);
    exp_q.push_back({1'b0, 1'b1, 32'hDEAD_BEEF});
    tick; ifu_bmu_req = 1'b0;
    tick;
    tick;
    check("d_vld", 64'(bmu_ifu_data_vld), 64'd1);
    check("d_data", 64'(bmu_ifu_data), 64'hDEAD_BEEF);
    check("d_err", 64'(bmu_ifu_acc_err), 64'd0);
    cfg_data = 32'hCAFE_0000;
    ifu_bmu_req = 1'b1; ifu_bmu_addr = 32'h0000_0200; #1;
    check("b2b_grnt", 64'(bmu_ifu_grnt), 64'd1);
    exp_q.push_back({1'b0, 1'b1, 32'hCAFE_0000});
    tick; ifu_bmu_req = 1'b0;
    check("b2b_data_clr", 64'(bmu_ifu_data), 64'd0);
    check("b2b_bus_addr", 64'(bmu_tcipif_ibus_addr), 64'h200);
    tick;
    tick;
    check("b2b_cmplt", 64'(bmu_ifu_trans_cmplt), 64'd1);
    check("b2b_data", 64'(bmu_ifu_data), 64'hCAFE_0000);
    tick;

    // Flush in IDLE blocks the grant
    ifu_bmu_req = 1'b1; ifu_bmu_flush = 1'b1; ifu_bmu_addr = 32'h0000_0280; #1;
    check("fi_grnt", 64'(bmu_ifu_grnt), 64'd0);
    tick;
    check("fi_bus_req", 64'(bmu_tcipif_ibus_req), 64'd0);
    ifu_bmu_req = 1'b0; ifu_bmu_flush = 1'b0;

    // Request held without grant, then dropped by flush
    gnt_en = 1'b0;
    ifu_bmu_req = 1'b1; ifu_bmu_addr = 32'h0000_0300; #1;
    check("fr_grnt", 64'(bmu_ifu_grnt), 64'd1);
    tick; ifu_bmu_req = 1'b0;
    check("fr_req1", 64'(bmu_tcipif_ibus_req), 64'd1);
    tick;
    check("fr_req_held", 64'(bmu_tcipif_ibus_req), 64'd1);
    check("fr_addr_held", 64'(bmu_tcipif_ibus_addr), 64'h300);
    ifu_bmu_flush = 1'b1;
    tick; ifu_bmu_flush = 1'b0;
    check("fr_dropped", 64'(bmu_tcipif_ibus_req), 64'd0);
    check("fr_idle", 64'(dbg_fetch_state), 64'd0);
    gnt_en = 1'b1;
    tick;

    // Flush in WAIT sets drop; the later completion is consumed silently
    auto_en = 1'b0; cfg_err = 1'b0; cfg_vld = 1'b1; cfg_data = 32'h1111_0000;
    ifu_bmu_req = 1'b1; ifu_bmu_addr = 32'h0000_0400; #1;
    check("fw_grnt", 64'(bmu_ifu_grnt), 64'd1);
    tick; ifu_bmu_req = 1'b0;
    tick;
    check("fw_wait", 64'(dbg_fetch_state), 64'd2);
    ifu_bmu_flush = 1'b1;
    tick; ifu_bmu_flush = 1'b0;
    check("fw_still_wait", 64'(dbg_fetch_state), 64'd2);
    inj_cmplt = 1'b1;
    tick; inj_cmplt = 1'b0;
    check("fw_no_cmplt", 64'(bmu_ifu_trans_cmplt), 64'd0);
    check("fw_idle", 64'(dbg_fetch_state), 64'd0);
    auto_en = 1'b1;
    ifu_bmu_req = 1'b1; ifu_bmu_addr = 32'h0000_0500; #1;
    check("fw_next_grnt", 64'(bmu_ifu_grnt), 64'd1);
    exp_q.push_back({1'b0, 1'b1, 32'h1111_0000});
    tick; ifu_bmu_req = 1'b0;
    tick;
    tick;
    check("fw_next_cmplt", 64'(bmu_ifu_trans_cmplt), 64'd1);
    check("fw_next_data", 64'(bmu_ifu_data), 64'h1111_0000);
    tick;

    // Reset while in WAIT, then a stray completion
    cfg_data = 32'h5555_AAAA;
    ifu_bmu_req = 1'b1; ifu_bmu_addr = 32'h0000_0600; #1;
    check("r_grnt", 64'(bmu_ifu_grnt), 64'd1);
    tick; ifu_bmu_req = 1'b0;
    tick;
    check("r_wait", 64'(dbg_fetch_state), 64'd2);
    cpurst_b = 1'b0; #1;
    check("r_cmplt", 64'(bmu_ifu_trans_cmplt), 64'd0);
    check("r_bus_req", 64'(bmu_tcipif_ibus_req), 64'd0);
    check("r_bus_addr", 64'(bmu_tcipif_ibus_addr), 64'd0);
    check("r_state", 64'(dbg_fetch_state), 64'd0);
    check("r_data", 64'(bmu_ifu_data), 64'd0);
    tick;
    cpurst_b = 1'b1;
    inj_cmplt = 1'b1;
    tick; inj_cmplt = 1'b0;
    check("r_stray_cmplt", 64'(bmu_ifu_trans_cmplt), 64'd0);
    check("r_stray_state", 64'(dbg_fetch_state), 64'd0);
    tick;
    check("r_stray_cmplt2", 64'(bmu_ifu_trans_cmplt), 64'd0);
    repeat (2) tick;

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
